// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
// The timer source is compiled in only when IRQ_TIMER_EN is defined.
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WFI_WAIT = 3'd1,
    ST_TAKE     = 3'd2,
    ST_HANDLER  = 3'd3,
    ST_RET      = 3'd4
  } irq_state_e;

  typedef enum logic {
    SRC_EXT = 1'b0,
    SRC_TMR = 1'b1
  } irq_src_e;

  // CSR bit positions feeding the enable inputs
  localparam int unsigned MSTATUS_MIE_BIT = 3;
  localparam int unsigned MIE_MTIE_BIT    = 7;
  localparam int unsigned MIE_MEIE_BIT    = 11;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer bringing the asynchronous external interrupt level
// into the clk domain; both flops clear on rst.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: trap entry/return sequencing, WFI wait.
// Define IRQ_TIMER_EN to enable the timer interrupt source; default is external only.
module irq_ctrl
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq_i,
  input  logic        timer_irq_i,
  input  logic        mstatus_mie_i,
  input  logic        mie_meie_i,
  input  logic        mie_mtie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        mret_i,
  input  logic        wfi_i,
  input  logic        stall_i,
  output logic        intr_ex_o,
  output logic        intr_t_o,
  output logic        intr_end_ex_o,
  output logic        intr_end_t_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        wfi_stall_o,
  output irq_state_e  dbg_state_o
);

  irq_state_e state, state_d;
  irq_src_e   src, src_d;
  logic       ext_s, ext_pend, tmr_pend, take, src_is_tmr;
  logic       unused_bits;

  irq_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_irq_i),
    .q   (ext_s)
  );

  assign ext_pend = ext_s & mie_meie_i;

`ifdef IRQ_TIMER_EN
  assign tmr_pend    = timer_irq_i & mie_mtie_i;
  assign src_is_tmr  = (src == SRC_TMR);
  assign unused_bits = ^mtvec_i[1:0];
`else
  assign tmr_pend    = 1'b0;
  assign src_is_tmr  = 1'b0;
  assign unused_bits = ^{mtvec_i[1:0], timer_irq_i, mie_mtie_i};
`endif

  assign take        = mstatus_mie_i & (ext_pend | tmr_pend);
  assign dbg_state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      src   <= SRC_EXT;
    end else begin
      state <= state_d;
      src   <= src_d;
    end
  end

  always_comb begin
    state_d = state;
    src_d   = src;
    unique case (state)
      ST_IDLE: begin
        if (take && !stall_i) begin
          state_d = ST_TAKE;
          src_d   = ext_pend ? SRC_EXT : SRC_TMR;
        end else if (wfi_i && !stall_i) begin
          state_d = ST_WFI_WAIT;
        end
      end
      // Any enabled pending line wakes the core; the global enable only
      // decides whether the wakeup also enters the trap.
      ST_WFI_WAIT: begin
        if (ext_pend || tmr_pend) begin
          if (take) begin
            state_d = ST_TAKE;
            src_d   = ext_pend ? SRC_EXT : SRC_TMR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TAKE:    state_d = ST_HANDLER;
      ST_HANDLER: if (mret_i && !stall_i) state_d = ST_RET;
      ST_RET:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    intr_ex_o     = 1'b0;
    intr_t_o      = 1'b0;
    intr_end_ex_o = 1'b0;
    intr_end_t_o  = 1'b0;
    redirect_o    = 1'b0;
    flush_o       = 1'b0;
    redirect_pc_o = 32'h0;
    wfi_stall_o   = 1'b0;
    unique case (state)
      ST_TAKE: begin
        intr_ex_o     = !src_is_tmr;
        intr_t_o      = src_is_tmr;
        redirect_o    = 1'b1;
        flush_o       = 1'b1;
        redirect_pc_o = {mtvec_i[31:2], 2'b00};
      end
      ST_RET: begin
        intr_end_ex_o = !src_is_tmr;
        intr_end_t_o  = src_is_tmr;
        redirect_o    = 1'b1;
        flush_o       = 1'b1;
        redirect_pc_o = mepc_i;
      end
      ST_WFI_WAIT: wfi_stall_o = 1'b1;
      default: ;
    endcase
  end

endmodule
